dmem_arbiter: RTL

Two-requester arbiter that shares the single-port, 12-bit-address, 32-bit-data synchronous dmem between the processor load/store path (requester 0) and a secondary master such as a debug/loader or I/O engine (requester 1). Each requester uses a req/gnt handshake. Read data returns one cycle after grant, matching the dmem syncram latency. Arbitration is round-robin with an optional bounded lock for bursts. The block sits between the requesters and the dmem instance, driving its address, data, wren and clock-domain-aligned controls.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous dmem between two
// requesters. Round-robin arbitration with a bounded ownership lock for
// bursts, same-cycle grant, read data returned one cycle after grant.
module dmem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic             last_q, last_d;
    logic             owner_lock_q, owner_lock_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rd_pend0_q, rd_pend0_d;
    logic             rd_pend1_q, rd_pend1_d;

    // Burst counter stops at MAX_BURST while an uncontested owner keeps going.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= BURST_MAX) ? BURST_MAX : v + CNT_W'(1);
    endfunction

    // Grant selection: single requester wins outright; under contention a
    // locked owner keeps the port until its burst budget is spent, else the
    // requester that was not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if (owner_lock_q && (burst_cnt_q < BURST_MAX)) begin
                    gnt0 = ~last_q;
                    gnt1 = last_q;
                end else begin
                    gnt0 = last_q;
                    gnt1 = ~last_q;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Route the granted requester onto the dmem port; idle port drives zeros.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (gnt0) begin
            mem_address = addr0;
            mem_data    = wdata0;
            mem_wren    = we0;
        end else if (gnt1) begin
            mem_address = addr1;
            mem_data    = wdata1;
            mem_wren    = we1;
        end
    end

    // Next-state for arbitration history and read-valid pipeline.
    always_comb begin
        last_d       = last_q;
        owner_lock_d = 1'b0;
        burst_cnt_d  = '0;
        rd_pend0_d   = gnt0 & ~we0;
        rd_pend1_d   = gnt1 & ~we1;
        if (gnt0 || gnt1) begin
            last_d       = gnt1;
            owner_lock_d = gnt1 ? lock1 : lock0;
            if ((gnt1 == last_q) && owner_lock_q) begin
                burst_cnt_d = sat_inc(burst_cnt_q);
            end else begin
                burst_cnt_d = CNT_W'(1);
            end
        end
    end

    // State registers; reset makes requester 0 win the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q       <= 1'b1;
            owner_lock_q <= 1'b0;
            burst_cnt_q  <= '0;
            rd_pend0_q   <= 1'b0;
            rd_pend1_q   <= 1'b0;
        end else begin
            last_q       <= last_d;
            owner_lock_q <= owner_lock_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pend0_q   <= rd_pend0_d;
            rd_pend1_q   <= rd_pend1_d;
        end
    end

    assign rvalid0 = rd_pend0_q;
    assign rvalid1 = rd_pend1_q;
    assign rdata0  = mem_q;
    assign rdata1  = mem_q;

endmodule
